lcd_host: RTL and testbench
===========================

LCD_HOST -- requirements
Module: lcd_host

Interface
- REQ-001 Parameter TIMEOUT, default 255: max cycles waited for busy to fall or output_valid to arrive before error.
- REQ-002 Parameter IMG_BASE, default 0: base offset added to img_addr.
- REQ-003 clk  input  1  clock; all state changes on rising edge.
- REQ-004 reset  input  1  reset, asynchronous, active-high.
- REQ-005 req_valid  input  1  host command request.
- REQ-006 req_cmd  input  3  0=Reflash 1=Load 2=Right 3=Left 4=Up 5=Down.
- REQ-007 req_ready  output  1  high only in IDLE.
- REQ-008 img_addr  output  6  pixel index 0..35 (+IMG_BASE mod 64) into image source.
- REQ-009 img_data  input  8  pixel for img_addr, same-cycle (combinational source).
- REQ-010 cmd  output  3  command to LCD controller.
- REQ-011 cmd_valid  output  1  one-cycle command strobe.
- REQ-012 datain  output  8  pixel stream to LCD controller.
- REQ-013 busy  input  1  LCD controller busy.
- REQ-014 dataout  input  8  window pixel from LCD controller.
- REQ-015 output_valid  input  1  dataout qualifier.
- REQ-016 win_data  output  8  captured window pixel.
- REQ-017 win_idx  output  4  position 0..8 of captured pixel, row-major.
- REQ-018 win_valid  output  1  win_data/win_idx valid, one cycle per pixel.
- REQ-019 done  output  1  one-cycle pulse after 9th pixel captured.
- REQ-020 error  output  1  sticky; timeout (and mismatch when checking compiled in).

Function
- REQ-021 FSM states IDLE, ISSUE, STREAM, COLLECT; reset state IDLE.
- REQ-022 IDLE: req_valid & req_ready & ~busy -> latch req_cmd, go ISSUE; req_valid while busy high is held, not dropped.
- REQ-023 ISSUE (exactly 1 cycle): cmd_valid=1, cmd=latched value; next STREAM if Load, else COLLECT.
- REQ-024 Illegal req_cmd 6/7: accepted, treated as Reflash, no error.
- REQ-025 STREAM: 36 consecutive cycles, beat counter k=0..35, img_addr=k, datain=img_data; then COLLECT.
- REQ-026 COLLECT: each output_valid cycle -> win_valid=1, win_data=dataout, win_idx=count, count++; at count 9 -> done pulse same cycle as 9th win_valid, go IDLE.
- REQ-027 output_valid outside COLLECT ignored; output_valid beyond 9th impossible (FSM leaves COLLECT).
- REQ-028 Timeout counter (8-bit sat. at TIMEOUT) resets on entering COLLECT and on each output_valid; reaching TIMEOUT -> error=1, go IDLE, no done.
- REQ-029 Window model: top-left (x,y) in 0..3; Load sets (2,2); Right x<3?x+1; Left x>0?x-1; Down y<3?y+1; Up y>0?y-1; Reflash no change; update in ISSUE.
- REQ-030 cmd_valid, win_valid, done low in every state except as above; datain holds last value outside STREAM.

Reset
- REQ-031 reset: state IDLE, req_ready=1 (after deassert), cmd=0, cmd_valid=0, datain=0, img_addr=0, win_*=0, done=0, error=0, (x,y)=(2,2), counters 0.
- REQ-032 reset mid-STREAM/COLLECT aborts immediately; no partial done.

Configuration
- REQ-033 Macro LCD_HOST_CHECK_EN: defined -> expected pixel for win_idx i = image[(y+i/3)*6 + (x+i%3)] read via second image port mirror (img_addr driven to expected index during COLLECT), mismatch sets error; undefined -> no check, img_addr=0 outside STREAM, error only from timeout.

Structure
- REQ-034 Package lcd_pkg: command enum (3-bit), IMG_W=6, WIN_W=3, PIX_N=36, WIN_N=9, FSM state enum.
- REQ-035 Sub-module lcd_win_model: holds (x,y), clamp logic, expected-index computation.

Verification
- REQ-036 Load with img_data=addr: cmd_valid 1 cycle cmd=1, 36 beats datain 0..35, then 9 captures -> done; with check model window {14,15,16,20,21,22,26,27,28} -> error=0.
- REQ-037 After Load, Right x2: second Right clamps at x=3; expected window starts 15.
- REQ-038 Up x3 after Load: y clamps 0; window {2,3,4,8,9,10,14,15,16}.
- REQ-039 LCD model never asserts output_valid -> error=1 after 255 cycles, returns IDLE, done never pulses.
- REQ-040 reset asserted at STREAM beat 10 -> all outputs at reset values next edge; fresh Load completes normally.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared command/state types and image/window geometry for the LCD host
package lcd_pkg;

   typedef enum logic [2:0] {
      CMD_REFLASH = 3'd0,
      CMD_LOAD    = 3'd1,
      CMD_RIGHT   = 3'd2,
      CMD_LEFT    = 3'd3,
      CMD_UP      = 3'd4,
      CMD_DOWN    = 3'd5
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, STREAM, COLLECT} state_t;

   localparam int IMG_W = 6;
   localparam int WIN_W = 3;
   localparam int PIX_N = 36;
   localparam int WIN_N = 9;

   function automatic cmd_t legal_cmd(input logic [2:0] c);
      return c > 3'd5 ? CMD_REFLASH : cmd_t'(c);
   endfunction

endpackage

// File: rtl/lcd_win_model.sv
// lcd_win_model: tracks the 3x3 window origin and yields the image index of a window position
module lcd_win_model
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       upd,
   input  cmd_t       op,
   input  logic [3:0] idx,
   output logic [5:0] exp_idx
);

   logic [1:0] x, y;

   // origin moves one step per command, clamped to the 0..3 range; Load recentres it
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         x <= 2'd2;
         y <= 2'd2;
      end else if (upd) begin
         x <= op == CMD_LOAD ? 2'd2 : op == CMD_RIGHT && x != 2'd3 ? x + 2'd1 :
              op == CMD_LEFT && x != 2'd0 ? x - 2'd1 : x;
         y <= op == CMD_LOAD ? 2'd2 : op == CMD_DOWN && y != 2'd3 ? y + 2'd1 :
              op == CMD_UP && y != 2'd0 ? y - 2'd1 : y;
      end

   // row-major index of window cell idx within the 6x6 image
   always_comb
      exp_idx = (6'(y) + 6'(idx / 4'(WIN_W))) * 6'(IMG_W) + 6'(x) + 6'(idx % 4'(WIN_W));

endmodule

// File: rtl/lcd_host.sv
// lcd_host: drives an LCD controller with commands and image data, collects the 3x3 window (LCD_HOST_CHECK_EN adds pixel checking)
module lcd_host
   import lcd_pkg::*;
#(
   parameter int TIMEOUT  = 255,
   parameter int IMG_BASE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_cmd,
   output logic       req_ready,
   output logic [5:0] img_addr,
   input  logic [7:0] img_data,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   output logic [7:0] datain,
   input  logic       busy,
   input  logic [7:0] dataout,
   input  logic       output_valid,
   output logic [7:0] win_data,
   output logic [3:0] win_idx,
   output logic       win_valid,
   output logic       done,
   output logic       error
);

   state_t     state, next;
   cmd_t       op;
   logic [5:0] k, exp_idx;
   logic [3:0] cnt;
   logic [7:0] tcnt, held;
   logic       timeout, last, mismatch;

   lcd_win_model u_win (
      .clk    (clk),
      .reset  (reset),
      .upd    (state == ISSUE),
      .op     (op),
      .idx    (cnt),
      .exp_idx(exp_idx)
   );

   assign req_ready = state == IDLE;
   assign cmd_valid = state == ISSUE;
   assign cmd       = op;
   assign datain    = state == STREAM ? img_data : held;
   assign timeout   = state == COLLECT && !output_valid && tcnt == 8'(TIMEOUT);
   assign last      = state == COLLECT && output_valid && cnt == 4'(WIN_N - 1);

`ifdef LCD_HOST_CHECK_EN
   assign img_addr = state == STREAM ? k + 6'(IMG_BASE) : state == COLLECT ? exp_idx + 6'(IMG_BASE) : 6'd0;
   assign mismatch = state == COLLECT && output_valid && dataout != img_data;
`else
   logic unused_exp;
   assign unused_exp = ^exp_idx;
   assign img_addr   = state == STREAM ? k + 6'(IMG_BASE) : 6'd0;
   assign mismatch   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= next;

   // next-state: one ISSUE cycle, 36 beats of STREAM for Load, COLLECT until 9 pixels or timeout
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (req_valid && !busy) next = ISSUE;
         ISSUE:   next = op == CMD_LOAD ? STREAM : COLLECT;
         STREAM:  if (k == 6'(PIX_N - 1)) next = COLLECT;
         COLLECT: if (last || timeout) next = IDLE;
      endcase
   end

   // datapath: command latch, beat/pixel/timeout counters, registered window outputs
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         op        <= CMD_REFLASH;
         k         <= 6'd0;
         cnt       <= 4'd0;
         tcnt      <= 8'd0;
         held      <= 8'd0;
         win_data  <= 8'd0;
         win_idx   <= 4'd0;
         win_valid <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         if (state == IDLE && next == ISSUE) op <= legal_cmd(req_cmd);
         k    <= state == STREAM && next == STREAM ? k + 6'd1 : 6'd0;
         cnt  <= state == COLLECT && next == COLLECT ? cnt + 4'(output_valid) : 4'd0;
         tcnt <= state != COLLECT || output_valid ? 8'd0 : tcnt == 8'(TIMEOUT) ? tcnt : tcnt + 8'd1;
         if (state == STREAM) held <= img_data;
         win_valid <= state == COLLECT && output_valid;
         if (state == COLLECT && output_valid) begin
            win_data <= dataout;
            win_idx  <= cnt;
         end
         done  <= last;
         error <= error || timeout || mismatch;
      end

endmodule

// File: tb/tb_lcd_host.sv
// tb_lcd_host: table-driven command sequences plus timeout, busy-hold and mid-stream reset cases
module tb_lcd_host;
   import lcd_pkg::*;

   logic       clk = 0, reset = 0, req_valid = 0, busy = 0, output_valid = 0;
   logic [2:0] req_cmd = 0;
   logic [7:0] dataout = 0;
   logic       req_ready, cmd_valid, win_valid, done, error;
   logic [5:0] img_addr;
   logic [7:0] img_data, datain, win_data;
   logic [2:0] cmd;
   logic [3:0] win_idx;

   int errors = 0, checks = 0, exp_held = 0;

   typedef struct {
      logic [2:0] c;
      logic [2:0] ec;
      int         base;
   } vec_t;
   vec_t tbl [16];

   lcd_host dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
      .img_addr(img_addr), .img_data(img_data), .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain),
      .busy(busy), .dataout(dataout), .output_valid(output_valid), .win_data(win_data),
      .win_idx(win_idx), .win_valid(win_valid), .done(done), .error(error)
   );

   assign img_data = {2'b00, img_addr};

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_cmd_valid"}, cmd_valid, 0);
      chk({tag, "_cmd"}, cmd, 0);
      chk({tag, "_img_addr"}, img_addr, 0);
      chk({tag, "_datain"}, datain, 0);
      chk({tag, "_win_valid"}, win_valid, 0);
      chk({tag, "_win_data"}, win_data, 0);
      chk({tag, "_win_idx"}, win_idx, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1;
      @(negedge clk) reset = 0;
      exp_held = 0;
   endtask

   task automatic issue(input logic [2:0] c, input logic [2:0] ec);
      @(negedge clk);
      chk("issue_req_ready", req_ready, 1);
      req_valid = 1;
      req_cmd   = c;
      @(negedge clk);
      req_valid = 0;
      chk("issue_cmd_valid", cmd_valid, 1);
      chk("issue_cmd", cmd, ec);
   endtask

   task automatic stream();
      int bad = 0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         if (k == 0) chk("stream_cmd_valid_pulse", cmd_valid, 0);
         if (img_addr != 6'(k) || datain != 8'(k)) bad++;
      end
      chk("stream_bad_beats", bad, 0);
      exp_held = 35;
   endtask

   task automatic collect(input int base, input logic eerr);
      int bad = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("collect_cmd_valid_low", cmd_valid, 0);
            chk("collect_datain_held", datain, exp_held);
         end
         output_valid = 1;
         dataout      = 8'(base + (i / 3) * 6 + i % 3);
         @(negedge clk);
         output_valid = 0;
         if (!(win_valid && win_data == dataout && win_idx == 4'(i) && done == (i == 8))) bad++;
      end
      chk("collect_bad_pixels", bad, 0);
      @(negedge clk);
      chk("collect_back_idle", req_ready, 1);
      chk("collect_win_valid_low", win_valid, 0);
      chk("collect_done_low", done, 0);
      chk("collect_error", error, eerr);
   endtask

   task automatic run(input vec_t v);
      issue(v.c, v.ec);
      if (v.ec == CMD_LOAD) stream();
      collect(v.base, 1'b0);
   endtask

   initial begin
      int j, dn;
      logic exp_mis;
      tbl[0]  = '{CMD_LOAD,    CMD_LOAD,    14};
      tbl[1]  = '{CMD_RIGHT,   CMD_RIGHT,   15};
      tbl[2]  = '{CMD_RIGHT,   CMD_RIGHT,   15};
      tbl[3]  = '{CMD_LOAD,    CMD_LOAD,    14};
      tbl[4]  = '{CMD_UP,      CMD_UP,       8};
      tbl[5]  = '{CMD_UP,      CMD_UP,       2};
      tbl[6]  = '{CMD_UP,      CMD_UP,       2};
      tbl[7]  = '{CMD_LEFT,    CMD_LEFT,     1};
      tbl[8]  = '{CMD_LEFT,    CMD_LEFT,     0};
      tbl[9]  = '{CMD_LEFT,    CMD_LEFT,     0};
      tbl[10] = '{CMD_DOWN,    CMD_DOWN,     6};
      tbl[11] = '{CMD_REFLASH, CMD_REFLASH,  6};
      tbl[12] = '{3'd7,        CMD_REFLASH,  6};
      tbl[13] = '{CMD_DOWN,    CMD_DOWN,    12};
      tbl[14] = '{CMD_DOWN,    CMD_DOWN,    18};
      tbl[15] = '{CMD_DOWN,    CMD_DOWN,    18};

      #1 reset = 1;
      @(negedge clk);
      chk_reset_values("reset");
      @(negedge clk) reset = 0;
      @(negedge clk);
      chk("post_reset_ready", req_ready, 1);

      for (int i = 0; i < 16; i++) run(tbl[i]);

`ifdef LCD_HOST_CHECK_EN
      exp_mis = 1'b1;
`else
      exp_mis = 1'b0;
`endif
      issue(CMD_REFLASH, CMD_REFLASH);
      collect(19, exp_mis);

      do_reset();
      issue(CMD_REFLASH, CMD_REFLASH);
      j  = 0;
      dn = 0;
      while (!error && j < 400) begin
         @(negedge clk);
         j++;
         if (done) dn++;
      end
      chk("timeout_error", error, 1);
      chk($sformatf("timeout_cycles_in_range(%0d)", j), int'(j >= 255 && j <= 258), 1);
      chk("timeout_no_done", dn, 0);
      chk("timeout_idle", req_ready, 1);
      @(negedge clk);
      chk("timeout_error_sticky", error, 1);

      do_reset();
      @(negedge clk);
      busy      = 1;
      req_valid = 1;
      req_cmd   = CMD_RIGHT;
      dn        = 0;
      repeat (3) begin
         @(negedge clk);
         if (cmd_valid) dn++;
      end
      chk("busy_hold_ready", req_ready, 1);
      chk("busy_hold_no_cmd", dn, 0);
      busy = 0;
      @(negedge clk);
      req_valid = 0;
      chk("busy_release_cmd_valid", cmd_valid, 1);
      chk("busy_release_cmd", cmd, CMD_RIGHT);
      collect(15, 1'b0);

      issue(CMD_LOAD, CMD_LOAD);
      for (int k = 0; k <= 10; k++) @(negedge clk);
      chk("midstream_beat10_addr", img_addr, 10);
      reset = 1;
      @(negedge clk);
      chk_reset_values("midstream_reset");
      reset    = 0;
      exp_held = 0;
      run(tbl[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
